// File: rtl/syscall_string_reader.sv
// syscall_string_reader
//
// Syscall output engine placed in front of the data memory read port. It runs
// while the CPU is stalled on a syscall instruction:
//   v0 == 4  : print_string. Walks a NUL-terminated string starting at byte
//              address a0, one aligned word fetch at a time, and emits each
//              character on a valid/ready byte stream. It stops at the NUL or
//              after MAX_LEN characters; the second case sets overflow.
//   v0 == 11 : print_char. Emits a0[7:0], including a zero byte.
//   other    : ignored.
//
// Handshake: char_out is a transfer when char_valid && char_ready are both high
// at a rising clock edge. While char_valid is high and char_ready is low,
// char_out is held stable. char_valid never drops without a transfer, except
// on reset.
//
// Ports:
//   clk, reset     system clock and synchronous active-high reset
//   syscall_start  one-cycle strobe; v0/a0 are sampled with it (IDLE only)
//   v0, a0         syscall code and argument
//   mem_addr       word-aligned byte address to data memory (0 when not reading)
//   mem_read       data memory read enable (high only in FETCH)
//   mem_data       combinational read data for mem_addr
//   char_out       character byte
//   char_valid     char_out valid
//   char_ready     sink accepts char_out this cycle
//   busy           CPU stall request; high in every state except IDLE
//   done           one-cycle completion pulse
//   overflow       sticky flag: last print_string hit MAX_LEN without a NUL
//   fsm_state      current FSM state, for observation
module syscall_string_reader #(
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        syscall_start,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    input  logic [31:0] mem_data,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EMIT  = 3'd2,
        CHAR  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    state_t           state_q;
    state_t           state_d;
    logic [31:0]      ptr;
    logic [31:0]      word;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       char_reg;
    logic             overflow_q;

    logic             start_string;
    logic             start_char;
    logic [7:0]       sel_byte;
    logic             emit_char;
    logic             hit_limit;
    logic             accept;

    // Starts are only honoured in IDLE; unknown codes leave the engine idle.
    assign start_string = (state_q == IDLE) && syscall_start && (v0 == 32'd4);
    assign start_char   = (state_q == IDLE) && syscall_start && (v0 == 32'd11);

    // Big-endian byte lane select: the lowest address is the most significant byte.
    always_comb begin
        sel_byte = 8'h00;
        case (ptr[1:0])
            2'd0: sel_byte = word[31:24];
            2'd1: sel_byte = word[23:16];
            2'd2: sel_byte = word[15:8];
            2'd3: sel_byte = word[7:0];
            default: sel_byte = 8'h00;
        endcase
    end

    // A character is offered only when the byte is not NUL and the limit is not yet reached.
    assign hit_limit = (sel_byte != 8'h00) && (cnt == MAX_CNT);
    assign emit_char = (state_q == EMIT) && (sel_byte != 8'h00) && (cnt != MAX_CNT);
    assign accept    = char_valid && char_ready;

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        mem_read   = 1'b0;
        mem_addr   = 32'h0;
        char_out   = 8'h00;
        char_valid = 1'b0;
        busy       = (state_q != IDLE);
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_string) begin
                    state_d = FETCH;
                end else if (start_char) begin
                    state_d = CHAR;
                end
            end
            FETCH: begin
                mem_read = 1'b1;
                mem_addr = {ptr[31:2], 2'b00};
                state_d  = EMIT;
            end
            EMIT: begin
                if (sel_byte == 8'h00 || hit_limit) begin
                    state_d = DONE;
                end else begin
                    char_out   = sel_byte;
                    char_valid = 1'b1;
                    // Leaving the last lane of the word needs a fresh fetch.
                    if (char_ready && ptr[1:0] == 2'd3) begin
                        state_d = FETCH;
                    end
                end
            end
            CHAR: begin
                char_out   = char_reg;
                char_valid = 1'b1;
                if (char_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr        <= 32'h0;
            word       <= 32'h0;
            cnt        <= '0;
            char_reg   <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_string) begin
                ptr        <= a0;
                cnt        <= '0;
                overflow_q <= 1'b0;
            end
            if (start_char) begin
                char_reg <= a0[7:0];
            end
            if (state_q == FETCH) begin
                word <= mem_data;
            end
            if (state_q == EMIT && hit_limit) begin
                overflow_q <= 1'b1;
            end
            if (emit_char && accept) begin
                ptr <= ptr + 32'd1;
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign fsm_state = state_q;

endmodule
